e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Parametrised multi-cycle multiply/divide unit for the E stage of the pipelined MIPS core.
- Owns the HI/LO registers and executes mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Models configurable latency and exposes Busy, so the D-stage stall logic can hold md-class instructions until the unit is idle.

Parameters:
- WIDTH, 32: operand and HI/LO width.
- MULT_CYCLES, 5: busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10: busy cycles for div/divu (>=1).

Ports:
- Clk  input  1  clock. Single clock domain, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  a valid md-class instruction occupies E this cycle. Bubbles drive 0.
- MDUOp  input  4  operation code; encodings in the shared header.
- A  input  WIDTH  forwarded rs value (e_rd1).
- B  input  WIDTH  forwarded rt value (e_rd2).
- Busy  output  1  an operation is in flight.
- Out  output  WIDTH  read data for mfhi/mflo; combinational from HI/LO.
- HI  output  WIDTH  current HI register.
- LO  output  WIDTH  current LO register.

Behaviour:
- Reset, asynchronous, any state: state=IDLE, count=0, HI=0, LO=0, pending results=0, Busy=0. Reset mid-operation discards the pending result.
- States: IDLE, MUL, DIV.
- IDLE, Start=1, op mult/multu:
  - Latch the 2*WIDTH product of A*B into pending {hi,lo}: signed for mult, zero-extended for multu.
  - Set count=MULT_CYCLES-1 and go to MUL.
- IDLE, Start=1, op div/divu:
  - Latch quotient into pending lo and remainder into pending hi.
  - Set count=DIV_CYCLES-1 and go to DIV.
- MUL/DIV: Busy=1. While count!=0, decrement count each cycle.
- Completion: on the edge where count==0, copy pending into HI/LO and return to IDLE. Busy falls in the same edge.
- Latency: Start in cycle t gives Busy in cycles t+1..t+N, N=MULT_CYCLES or DIV_CYCLES. HI/LO hold the new values from cycle t+N+1.
- Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN/-1: quotient=MIN, remainder=0.
- Divide by zero, signed or unsigned: operation still occupies the unit for DIV_CYCLES cycles. HI and LO are left unchanged at completion.
- mthi / mtlo with Start=1 in IDLE: HI or LO takes A at the next edge. Busy stays 0.
- mfhi / mflo: Out=HI or LO combinationally. Any other MDUOp gives Out=0. Reading during Busy returns the old value.
- Start=1 while Busy=1: ignored entirely, with no state change. D-stage stall must prevent this; the bench asserts it never occurs in legal programs.
- Required stall contract for the hazard logic: stall any D-stage md-class instruction while (Start & E op is mult/div) | Busy.
- Unknown MDUOp with Start=1: no state change.
- Arithmetic:
  - Products are computed at full 2*WIDTH precision.
  - All results truncate to WIDTH per register.
  - The counter is $clog2(max(MULT_CYCLES,DIV_CYCLES)+1) bits wide.

Decomposition:
- Shared header (`define style) holds:
  - MDUOp encodings: mdu_none=0, mult=1, multu=2, div=3, divu=4, mfhi=5, mflo=6, mthi=7, mtlo=8.
  - State encodings.
  - An md-class predicate used by both e_mdu and D_STALL.
- The control word gains a 4-bit mdu_op field and an md-class flag.
- One natural sub-module: e_mdu_arith. It is combinational and computes signed/unsigned product, quotient and remainder with the divide-by-zero and overflow rules.
- FSM, counter and HI/LO stay in e_mdu.

Test Plan:
1. mult, MULT_CYCLES=5, A=0xFFFFFFFE (-2), B=3 -> Busy high for exactly 5 cycles after Start. Then HI=0xFFFFFFFF, LO=0xFFFFFFFA. mflo during Busy returns the old LO.
2. multu, A=0xFFFFFFFE, B=3 -> HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
3. div, DIV_CYCLES=10, A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1) after 10 busy cycles. Then divu with the same operands -> LO=0x7FFFFFFC, HI=1.
4. Preload mthi 0x1234 and mtlo 0x5678 (each visible the next cycle, Busy never asserted). Then div by B=0 -> Busy 10 cycles, after which HI=0x1234, LO=0x5678. Then div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
5. Start mult, assert Reset asynchronously mid-Busy (cycle 3) -> Busy, HI and LO go to 0 immediately, state IDLE. The next Start behaves normally.
6. Second mult with Start while Busy=1 -> ignored: busy window not extended, HI/LO equal the first result. Separately, parameter sweep MULT_CYCLES=1 and DIV_CYCLES=1 -> Busy high exactly one cycle.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: definitions shared by the E-stage multiply/divide unit and the
// D-stage stall logic.
//   - MDUOp encodings (4 bits)
//   - FSM state encodings (2 bits)
//   - control-word fields for md-class instructions
//   - is_md_class(): predicate used by e_mdu and D_STALL
//   - mdu_cnt_width(): width of the busy-cycle counter
package e_mdu_pkg;

  // MDUOp encodings
  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  // Control-word extension carried down the pipe for md-class instructions.
  typedef struct packed {
    logic [3:0] mdu_op;
    logic       md_class;
  } mdu_ctrl_t;

  // Any instruction that reads or writes HI/LO, or starts a mult/div.
  // D_STALL holds these while the unit is busy or about to become busy.
  function automatic logic is_md_class(input logic [3:0] op);
    return (op >= MDU_MULT) && (op <= MDU_MTLO);
  endfunction

  // Operation that makes the unit busy (used for the Start-in-E stall term).
  function automatic logic is_md_long(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  // Counter width: $clog2(max(mult, div) + 1).
  function automatic int mdu_cnt_width(input int mult_cycles, input int div_cycles);
    int m;
    m = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return (m + 1 > 2) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// e_mdu_arith: combinational arithmetic for e_mdu.
// Ports:
//   a_i, b_i        operands (WIDTH)
//   prod_s_o        signed 2*WIDTH product
//   prod_u_o        unsigned 2*WIDTH product
//   quot_s_o/rem_s_o signed quotient (toward zero) / remainder (dividend sign)
//   quot_u_o/rem_u_o unsigned quotient / remainder
//   div_zero_o      divisor is zero; quotient/remainder outputs are don't-care
module e_mdu_arith #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] prod_s_o,
  output logic [2*WIDTH-1:0] prod_u_o,
  output logic [WIDTH-1:0]   quot_s_o,
  output logic [WIDTH-1:0]   rem_s_o,
  output logic [WIDTH-1:0]   quot_u_o,
  output logic [WIDTH-1:0]   rem_u_o,
  output logic               div_zero_o
);

  logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, mag_safe;
  logic [WIDTH-1:0]   q_mag, r_mag;

  // Full-precision products: extend first, then multiply at 2*WIDTH.
  assign a_sx = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign b_sx = {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign a_zx = {{WIDTH{1'b0}}, a_i};
  assign b_zx = {{WIDTH{1'b0}}, b_i};

  assign prod_s_o = a_sx * b_sx;
  assign prod_u_o = a_zx * b_zx;

  assign div_zero_o = (b_i == '0);

  // Substitute a divisor of 1 on divide-by-zero so no X leaks out; the
  // caller discards the result in that case anyway.
  assign b_safe = div_zero_o ? WIDTH'(1) : b_i;

  assign quot_u_o = a_i / b_safe;
  assign rem_u_o  = a_i % b_safe;

  // Signed divide via magnitudes. |MIN| is representable as an unsigned
  // WIDTH-bit value, so MIN / -1 gives magnitude 2^(WIDTH-1), which negates
  // back to MIN with remainder 0 -- the overflow rule falls out naturally.
  assign a_neg    = a_i[WIDTH-1];
  assign b_neg    = b_i[WIDTH-1];
  assign a_mag    = a_neg ? (~a_i + WIDTH'(1)) : a_i;
  assign b_mag    = b_neg ? (~b_i + WIDTH'(1)) : b_i;
  assign mag_safe = div_zero_o ? WIDTH'(1) : b_mag;

  assign q_mag = a_mag / mag_safe;
  assign r_mag = a_mag % mag_safe;

  assign quot_s_o = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
  assign rem_s_o  = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;

endmodule

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit for the E stage; owns HI/LO.
// Ports:
//   Clk, Reset   clock (rising edge), asynchronous active-high reset
//   Start        valid md-class instruction in E this cycle
//   MDUOp        operation code (e_mdu_pkg encodings)
//   A, B         forwarded rs / rt values
//   Busy         mult/div in flight
//   Out          mfhi/mflo read data, combinational from HI/LO (0 otherwise)
//   HI, LO       current HI/LO registers
//   DbgState     current FSM state (ST_IDLE/ST_MUL/ST_DIV)
// Handshake: Start is only accepted in IDLE. Start while Busy is dropped with
// no state change; the D-stage must stall md-class instructions while
// (Start & is_md_long(MDUOp)) | Busy so this never happens.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       MDUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [1:0]       DbgState
);

  localparam int CW = mdu_cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;  // 0 for divide-by-zero

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   quot_s, rem_s, quot_u, rem_u;
  logic               div_zero;

  e_mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .a_i        (A),
    .b_i        (B),
    .prod_s_o   (prod_s),
    .prod_u_o   (prod_u),
    .quot_s_o   (quot_s),
    .rem_s_o    (rem_s),
    .quot_u_o   (quot_u),
    .rem_u_o    (rem_u),
    .div_zero_o (div_zero)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          case (MDUOp)
            MDU_MULT: begin
              pend_hi_d = prod_s[2*WIDTH-1:WIDTH];
              pend_lo_d = prod_s[WIDTH-1:0];
              pend_wr_d = 1'b1;
              count_d   = MUL_LOAD;
              state_d   = ST_MUL;
            end
            MDU_MULTU: begin
              pend_hi_d = prod_u[2*WIDTH-1:WIDTH];
              pend_lo_d = prod_u[WIDTH-1:0];
              pend_wr_d = 1'b1;
              count_d   = MUL_LOAD;
              state_d   = ST_MUL;
            end
            MDU_DIV: begin
              pend_hi_d = rem_s;
              pend_lo_d = quot_s;
              pend_wr_d = ~div_zero;
              count_d   = DIV_LOAD;
              state_d   = ST_DIV;
            end
            MDU_DIVU: begin
              pend_hi_d = rem_u;
              pend_lo_d = quot_u;
              pend_wr_d = ~div_zero;
              count_d   = DIV_LOAD;
              state_d   = ST_DIV;
            end
            MDU_MTHI: hi_d = A;
            MDU_MTLO: lo_d = A;
            default: ;  // mfhi/mflo/none/unknown: no state change
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        // Start is ignored here; only the counter advances.
        if (count_q != '0) begin
          count_d = count_q - CW'(1);
        end else begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Read port reflects committed HI/LO, so reads during Busy see old values.
  always_comb begin
    Out = '0;
    case (MDUOp)
      MDU_MFHI: Out = hi_q;
      MDU_MFLO: Out = lo_q;
      default:  Out = '0;
    endcase
  end

  assign Busy     = (state_q != ST_IDLE);
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign DbgState = state_q;

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed bench for e_mdu (default latencies) plus a second
// instance with MULT_CYCLES=DIV_CYCLES=1.
module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  // main DUT
  logic         Start;
  logic [3:0]   MDUOp;
  logic [W-1:0] A, B;
  logic         Busy;
  logic [W-1:0] Out, HI, LO;
  logic [1:0]   DbgState;

  e_mdu #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .MDUOp(MDUOp), .A(A), .B(B),
    .Busy(Busy), .Out(Out), .HI(HI), .LO(LO), .DbgState(DbgState)
  );

  // single-cycle DUT
  logic         start2;
  logic [3:0]   op2;
  logic [W-1:0] a2, b2;
  logic         busy2;
  logic [W-1:0] out2, hi2, lo2;
  logic [1:0]   state2;

  e_mdu #(.WIDTH(W), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut_fast (
    .Clk(Clk), .Reset(Reset), .Start(start2), .MDUOp(op2), .A(a2), .B(b2),
    .Busy(busy2), .Out(out2), .HI(hi2), .LO(lo2), .DbgState(state2)
  );

  // ---------------- scoreboard ----------------
  int total_cnt = 0;
  int pass_cnt  = 0;
  int nbusy;

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Present one Start for one cycle; returns at the negedge of cycle t+1.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    @(negedge Clk);
    Start = 1'b1; MDUOp = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; MDUOp = MDU_NONE; A = '0; B = '0;
  endtask

  // Count Busy cycles from the current negedge; bounded at 100.
  task automatic count_busy(output int n);
    n = 0;
    while (Busy && n < 100) begin
      n++;
      @(negedge Clk);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    Reset = 1'b1; Start = 1'b0; MDUOp = MDU_NONE; A = '0; B = '0;
    start2 = 1'b0; op2 = MDU_NONE; a2 = '0; b2 = '0;
    repeat (2) @(negedge Clk);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    check("reset_state", {30'd0, DbgState}, {30'd0, ST_IDLE});
    Reset = 1'b0;

    // preload LO so the read-during-busy check sees a distinct old value
    issue(MDU_MTLO, 32'h0000CAFE, 32'd0);
    check("mtlo_busy", {31'd0, Busy}, 32'd0);
    check("mtlo_lo", LO, 32'h0000CAFE);

    // test 1: mult -2 * 3
    issue(MDU_MULT, 32'hFFFFFFFE, 32'd3);
    MDUOp = MDU_MFLO;
    #1 check("t1_mflo_old", Out, 32'h0000CAFE);
    MDUOp = MDU_NONE;
    count_busy(nbusy);
    check("t1_busy_len", nbusy, 32'd5);
    check("t1_hi", HI, 32'hFFFFFFFF);
    check("t1_lo", LO, 32'hFFFFFFFA);
    MDUOp = MDU_MFHI;
    #1 check("t1_mfhi", Out, 32'hFFFFFFFF);
    MDUOp = MDU_NONE;
    #1 check("out_none", Out, 32'd0);

    // test 2: multu
    issue(MDU_MULTU, 32'hFFFFFFFE, 32'd3);
    count_busy(nbusy);
    check("t2_busy_len", nbusy, 32'd5);
    check("t2_hi", HI, 32'h00000002);
    check("t2_lo", LO, 32'hFFFFFFFA);

    // test 3: div / divu -7, 2
    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2);
    check("t3_state_div", {30'd0, DbgState}, {30'd0, ST_DIV});
    count_busy(nbusy);
    check("t3_busy_len", nbusy, 32'd10);
    check("t3_lo", LO, 32'hFFFFFFFD);
    check("t3_hi", HI, 32'hFFFFFFFF);
    issue(MDU_DIVU, 32'hFFFFFFF9, 32'd2);
    count_busy(nbusy);
    check("t3u_busy_len", nbusy, 32'd10);
    check("t3u_lo", LO, 32'h7FFFFFFC);
    check("t3u_hi", HI, 32'h00000001);

    // test 4: mthi/mtlo, divide by zero, MIN / -1
    issue(MDU_MTHI, 32'h00001234, 32'd0);
    check("t4_mthi_busy", {31'd0, Busy}, 32'd0);
    check("t4_mthi", HI, 32'h00001234);
    issue(MDU_MTLO, 32'h00005678, 32'd0);
    check("t4_mtlo_busy", {31'd0, Busy}, 32'd0);
    check("t4_mtlo", LO, 32'h00005678);
    issue(MDU_DIV, 32'd99, 32'd0);
    count_busy(nbusy);
    check("t4_dz_busy_len", nbusy, 32'd10);
    check("t4_dz_hi", HI, 32'h00001234);
    check("t4_dz_lo", LO, 32'h00005678);
    issue(MDU_DIVU, 32'd99, 32'd0);
    count_busy(nbusy);
    check("t4_dzu_busy_len", nbusy, 32'd10);
    check("t4_dzu_hi", HI, 32'h00001234);
    check("t4_dzu_lo", LO, 32'h00005678);
    issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
    count_busy(nbusy);
    check("t4_ovf_lo", LO, 32'h80000000);
    check("t4_ovf_hi", HI, 32'h00000000);

    // unknown op with Start: no state change
    issue(4'd12, 32'hDEADBEEF, 32'd1);
    check("unk_busy", {31'd0, Busy}, 32'd0);
    check("unk_hi", HI, 32'h00000000);
    check("unk_lo", LO, 32'h80000000);

    // test 5: asynchronous reset mid-busy
    issue(MDU_MULT, 32'd6, 32'd7);
    @(negedge Clk); @(negedge Clk);  // busy cycle 3
    #2 Reset = 1'b1;
    #1 check("t5_busy", {31'd0, Busy}, 32'd0);
    check("t5_hi", HI, 32'd0);
    check("t5_lo", LO, 32'd0);
    check("t5_state", {30'd0, DbgState}, {30'd0, ST_IDLE});
    @(negedge Clk);
    Reset = 1'b0;
    issue(MDU_MULT, 32'd6, 32'd7);
    count_busy(nbusy);
    check("t5_busy_len", nbusy, 32'd5);
    check("t5_lo_after", LO, 32'd42);
    check("t5_hi_after", HI, 32'd0);

    // test 6: Start while Busy is ignored
    issue(MDU_MULT, 32'd5, 32'd7);
    Start = 1'b1; MDUOp = MDU_MULT; A = 32'd100; B = 32'd100;
    @(negedge Clk);
    Start = 1'b0; MDUOp = MDU_NONE; A = '0; B = '0;
    count_busy(nbusy);
    check("t6_busy_len", nbusy + 1, 32'd5);
    check("t6_lo", LO, 32'd35);
    check("t6_hi", HI, 32'd0);
    @(negedge Clk);
    check("t6_no_restart", {31'd0, Busy}, 32'd0);

    // parameter sweep: single-cycle latency
    @(negedge Clk);
    start2 = 1'b1; op2 = MDU_MULT; a2 = 32'd3; b2 = 32'd4;
    @(negedge Clk);
    start2 = 1'b0; op2 = MDU_NONE;
    check("f_mul_busy1", {31'd0, busy2}, 32'd1);
    @(negedge Clk);
    check("f_mul_busy0", {31'd0, busy2}, 32'd0);
    check("f_mul_lo", lo2, 32'd12);
    start2 = 1'b1; op2 = MDU_DIVU; a2 = 32'd9; b2 = 32'd2;
    @(negedge Clk);
    start2 = 1'b0; op2 = MDU_NONE;
    check("f_div_busy1", {31'd0, busy2}, 32'd1);
    @(negedge Clk);
    check("f_div_busy0", {31'd0, busy2}, 32'd0);
    check("f_div_lo", lo2, 32'd4);
    check("f_div_hi", hi2, 32'd1);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

endmodule
